regfile_mp: RTL and testbench

//  Parametrised multi-read-port integer register file with hardware clear-on-reset sweep,

---
 rtl/regfile_mp.sv | 125 ++++++++++++
 tb/tb_regfile_mp.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Multi-read-port register file with post-reset clear sweep, optional write-to-read
// bypass and a per-register busy scoreboard. Register 0 always reads zero.

module regfile_mp_rd #(
    parameter int XLEN   = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic            ready_i,
    input  logic [AW-1:0]   raddr_i,
    input  logic [XLEN-1:0] rval_i,
    input  logic            busy_i,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            rbusy_o
);
    logic hit;
    assign hit = (BYPASS != 0) && we_i && (waddr_i == raddr_i);

    // Outputs are forced quiet until the sweep has defined every register.
    always_comb begin
        rdata_o = '0;
        rbusy_o = 1'b0;
        if (ready_i && raddr_i != '0) begin
            rdata_o = hit ? wdata_i : rval_i;
            rbusy_o = busy_i && !hit;
        end
    end
endmodule

module regfile_mp #(
    parameter int XLEN       = 32,
    parameter int REG_COUNT  = 32,
    parameter int READ_PORTS = 2,
    parameter int BYPASS     = 1,
    localparam int AW        = $clog2(REG_COUNT)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    output logic                       ready,
    input  logic                       we,
    input  logic [AW-1:0]              waddr,
    input  logic [XLEN-1:0]            wdata,
    input  logic [READ_PORTS*AW-1:0]   raddr,
    output logic [READ_PORTS*XLEN-1:0] rdata,
    output logic [READ_PORTS-1:0]      rbusy,
    input  logic                       reserve_en,
    input  logic [AW-1:0]              reserve_addr,
    input  logic                       flush
);
    typedef enum logic {INIT, RUN} state_t;

    state_t              state_q;
    logic [AW-1:0]       ptr_q;
    logic                ready_q;
    logic [XLEN-1:0]     regs_q [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q, busy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            ptr_q   <= AW'(1);
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    ptr_q <= ptr_q + AW'(1);
                    if (ptr_q == AW'(REG_COUNT - 1)) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage has no reset: the sweep clears it, so contents are defined once ready rises.
    always_ff @(posedge clk) begin
        if (state_q == INIT)
            regs_q[ptr_q] <= '0;
        else if (we && waddr != '0)
            regs_q[waddr] <= wdata;
    end

    always_comb begin
        busy_d = busy_q;
        if (state_q == RUN) begin
            for (int r = 1; r < REG_COUNT; r++) begin
                if (flush)
                    busy_d[r] = 1'b0;
                else if (reserve_en && reserve_addr == AW'(r))
                    busy_d[r] = 1'b1;
                else if (we && waddr == AW'(r))
                    busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign ready = ready_q;

    for (genvar i = 0; i < READ_PORTS; i++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = raddr[i*AW +: AW];
        regfile_mp_rd #(.XLEN(XLEN), .AW(AW), .BYPASS(BYPASS)) u_rd (
            .ready_i (ready_q),
            .raddr_i (ra),
            .rval_i  (regs_q[ra]),
            .busy_i  (busy_q[ra]),
            .we_i    (we),
            .waddr_i (waddr),
            .wdata_i (wdata),
            .rdata_o (rdata[i*XLEN +: XLEN]),
            .rbusy_o (rbusy[i])
        );
    end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a bypassed and a non-bypassed instance share stimulus.

module tb_regfile_mp;
    logic        clk;
    logic        rst_n;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic        reserve_en;
    logic [4:0]  reserve_addr;
    logic        flush;
    logic        rdy1, rdy0;
    logic [63:0] rd1, rd0;
    logic [1:0]  rb1, rb0;

    int n_chk = 0;
    int n_fail = 0;

    regfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst_n(rst_n), .ready(rdy1), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rd1), .rbusy(rb1), .reserve_en(reserve_en),
        .reserve_addr(reserve_addr), .flush(flush)
    );

    regfile_mp #(.BYPASS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .ready(rdy0), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rd0), .rbusy(rb0), .reserve_en(reserve_en),
        .reserve_addr(reserve_addr), .flush(flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        reserve_en = 1'b0; reserve_addr = '0; flush = 1'b0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, " rd1 p0"}, rd1[31:0], 32'h0);
        chk({nm, " rd1 p1"}, rd1[63:32], 32'h0);
        chk({nm, " rb1"}, {30'b0, rb1}, 32'h0);
        chk({nm, " rd0 p0"}, rd0[31:0], 32'h0);
        chk({nm, " rb0"}, {30'b0, rb0}, 32'h0);
    endtask

    task automatic sweep_wait(input string nm);
        for (int i = 1; i <= 31; i++) begin
            step();
            chk($sformatf("%s ready1 edge%0d", nm, i), {31'b0, rdy1}, (i == 31) ? 32'h1 : 32'h0);
            chk($sformatf("%s ready0 edge%0d", nm, i), {31'b0, rdy0}, (i == 31) ? 32'h1 : 32'h0);
        end
    endtask

    task automatic all_zero(input string nm);
        idle();
        for (int r = 0; r < 32; r++) begin
            raddr = {5'(r), 5'(r)};
            #1;
            chk($sformatf("%s r%0d p0", nm, r), rd1[31:0], 32'h0);
            chk($sformatf("%s r%0d p1", nm, r), rd1[63:32], 32'h0);
            chk($sformatf("%s r%0d nb", nm, r), rd0[31:0], 32'h0);
            chk($sformatf("%s r%0d busy", nm, r), {30'b0, rb1}, 32'h0);
        end
    endtask

    typedef struct {
        int we, wa, wd, ra0, ra1, re, rsa, fl;
        int e_rd0, e_rd1, e_rb;
        int n_rd0, n_rd1, n_rb;
    } vec_t;

    vec_t vt[21];

    initial begin
        //        we wa wd            ra0 ra1 re rsa fl  e_rd0         e_rd1        e_rb n_rd0        n_rd1        n_rb
        vt[0]  = '{1, 5, 'h12345678,  5, 5,  0, 0,  0,  'h12345678, 'h12345678, 0,  0,           0,           0};
        vt[1]  = '{0, 0, 0,           5, 5,  0, 0,  0,  'h12345678, 'h12345678, 0,  'h12345678, 'h12345678, 0};
        vt[2]  = '{1, 0, 'hFFFFFFFF,  0, 5,  0, 0,  0,  0,           'h12345678, 0,  0,           'h12345678, 0};
        vt[3]  = '{0, 0, 0,           0, 0,  0, 0,  0,  0,           0,           0,  0,           0,           0};
        vt[4]  = '{1, 7, 42,          7, 5,  0, 0,  0,  42,          'h12345678, 0,  0,           'h12345678, 0};
        vt[5]  = '{0, 0, 0,           7, 7,  0, 0,  0,  42,          42,          0,  42,          42,          0};
        vt[6]  = '{0, 0, 0,           3, 5,  1, 3,  0,  0,           'h12345678, 0,  0,           'h12345678, 0};
        vt[7]  = '{0, 0, 0,           3, 3,  0, 0,  0,  0,           0,           3,  0,           0,           3};
        vt[8]  = '{1, 3, 'hAA,        3, 5,  0, 0,  0,  'hAA,        'h12345678, 0,  0,           'h12345678, 1};
        vt[9]  = '{0, 0, 0,           3, 3,  0, 0,  0,  'hAA,        'hAA,        0,  'hAA,        'hAA,        0};
        vt[10] = '{1, 3, 'hBB,        3, 3,  1, 3,  0,  'hBB,        'hBB,        0,  'hAA,        'hAA,        0};
        vt[11] = '{0, 0, 0,           3, 3,  0, 0,  0,  'hBB,        'hBB,        3,  'hBB,        'hBB,        3};
        vt[12] = '{0, 0, 0,           1, 3,  1, 1,  0,  0,           'hBB,        2,  0,           'hBB,        2};
        vt[13] = '{0, 0, 0,           1, 2,  1, 2,  0,  0,           0,           1,  0,           0,           1};
        vt[14] = '{0, 0, 0,           2, 4,  1, 4,  0,  0,           0,           1,  0,           0,           1};
        vt[15] = '{0, 0, 0,           4, 6,  1, 6,  1,  0,           0,           1,  0,           0,           1};
        vt[16] = '{0, 0, 0,           6, 1,  0, 0,  0,  0,           0,           0,  0,           0,           0};
        vt[17] = '{0, 0, 0,           2, 4,  0, 0,  0,  0,           0,           0,  0,           0,           0};
        vt[18] = '{0, 0, 0,           3, 4,  0, 0,  0,  'hBB,        0,           0,  'hBB,        0,           0};
        vt[19] = '{0, 0, 0,           0, 0,  1, 0,  0,  0,           0,           0,  0,           0,           0};
        vt[20] = '{0, 0, 0,           0, 5,  0, 0,  0,  0,           'h12345678, 0,  0,           'h12345678, 0};

        rst_n = 1'b0;
        idle();
        raddr = {5'd5, 5'd0};
        step();
        chk("reset ready1", {31'b0, rdy1}, 32'h0);
        chk("reset ready0", {31'b0, rdy0}, 32'h0);
        chk_quiet("reset");
        rst_n = 1'b1;
        #1;
        chk("release ready1", {31'b0, rdy1}, 32'h0);
        sweep_wait("sweep1");
        all_zero("clear1");

        for (int k = 0; k < 21; k++) begin
            we = 1'(vt[k].we); waddr = 5'(vt[k].wa); wdata = 32'(vt[k].wd);
            raddr = {5'(vt[k].ra1), 5'(vt[k].ra0)};
            reserve_en = 1'(vt[k].re); reserve_addr = 5'(vt[k].rsa); flush = 1'(vt[k].fl);
            #1;
            chk($sformatf("v%0d rd0 byp", k), rd1[31:0], 32'(vt[k].e_rd0));
            chk($sformatf("v%0d rd1 byp", k), rd1[63:32], 32'(vt[k].e_rd1));
            chk($sformatf("v%0d rbusy byp", k), {30'b0, rb1}, 32'(vt[k].e_rb));
            chk($sformatf("v%0d rd0 nobyp", k), rd0[31:0], 32'(vt[k].n_rd0));
            chk($sformatf("v%0d rd1 nobyp", k), rd0[63:32], 32'(vt[k].n_rd1));
            chk($sformatf("v%0d rbusy nobyp", k), {30'b0, rb0}, 32'(vt[k].n_rb));
            step();
        end

        // Mid-run reset with a pending reservation on r3.
        idle();
        reserve_en = 1'b1; reserve_addr = 5'd3;
        step();
        idle();
        raddr = {5'd5, 5'd3};
        #1;
        chk("pre-rst busy r3", {30'b0, rb1}, 32'h1);
        chk("pre-rst r5", rd1[63:32], 32'h12345678);
        rst_n = 1'b0;
        #1;
        chk("midrst ready1", {31'b0, rdy1}, 32'h0);
        chk_quiet("midrst");
        step();
        rst_n = 1'b1;
        we = 1'b1; waddr = 5'd9; wdata = 32'hDEADBEEF;
        reserve_en = 1'b1; reserve_addr = 5'd9;
        raddr = {5'd5, 5'd9};
        #1;
        chk_quiet("init");
        sweep_wait("sweep2");
        all_zero("clear2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
